rcv_filt_sym_pipe: RTL and testbench

//  Parametrised, pipelined, symmetric odd-length FIR receive filter. Successor to the fixed 21-tap RCV filter.

---
 rtl/rcv_filt_sym_pipe.sv | 78 +++++++
 tb/tb_rcv_filt_sym_pipe.sv | 186 ++++++++++++++++++
 2 files changed

// File: rtl/rcv_filt_sym_pipe.sv
// rcv_filt_sym_pipe: pipelined symmetric odd-length FIR with round/saturate and double-buffered coefficients
module rcv_filt_sym_pipe #(
  parameter int N_TAPS = 21,
  parameter int DW = 18,
  parameter int CW = 18,
  localparam int M = (N_TAPS + 1) / 2,
  localparam int AW = $clog2(M)
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 sam_en,
  input  logic signed [DW-1:0] x_in,
  input  logic                 coef_wr,
  input  logic [AW-1:0]        coef_addr,
  input  logic signed [CW-1:0] coef_data,
  input  logic                 coef_commit,
  output logic                 commit_busy,
  output logic signed [DW-1:0] y,
  output logic                 y_valid
);
  localparam int PW = DW + CW + 1;
  localparam int ACW = PW + $clog2(M);
  localparam int RND = 2 ** (CW - 2);
  localparam int YMAX = 2 ** (DW - 1) - 1;
  localparam int YMIN = -(2 ** (DW - 1));
  localparam int CUNITY = 2 ** (CW - 1) - 1;

  logic signed [DW-1:0]  x [N_TAPS];
  logic signed [DW:0]    pre [M];
  logic signed [PW-1:0]  prod [M];
  logic signed [CW-1:0]  shadow [M];
  logic signed [CW-1:0]  active [M];
  logic signed [ACW-1:0] acc, acc_c;
  logic signed [ACW:0]   rnd, shr;
  logic signed [DW-1:0]  y_sat;
  logic                  v0, v1, v2, v3;

  always_comb begin
    acc_c = '0;
    for (int k = 0; k < M; k++) acc_c = acc_c + ACW'(prod[k]);
    rnd = (ACW+1)'(acc) + (ACW+1)'(RND);
    shr = rnd >>> (CW - 1);
    y_sat = shr > (ACW+1)'(YMAX) ? DW'(YMAX) : shr < (ACW+1)'(YMIN) ? DW'(YMIN) : DW'(shr);
  end

  // the pipeline free-runs; the valid token marks which stage holds a real sample
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < N_TAPS; i++) x[i] <= '0;
      for (int k = 0; k < M; k++) begin
        pre[k] <= '0;
        prod[k] <= '0;
        shadow[k] <= k == M - 1 ? CW'(CUNITY) : '0;
        active[k] <= k == M - 1 ? CW'(CUNITY) : '0;
      end
      acc <= '0;
      {v0, v1, v2, v3} <= '0;
      y <= '0;
      y_valid <= 1'b0;
      commit_busy <= 1'b0;
    end else begin
      if (sam_en) begin
        x[0] <= x_in;
        for (int i = 1; i < N_TAPS; i++) x[i] <= x[i-1];
      end
      for (int k = 0; k < M - 1; k++) pre[k] <= (DW+1)'(x[k]) + (DW+1)'(x[N_TAPS-1-k]);
      pre[M-1] <= (DW+1)'(x[M-1]);
      for (int k = 0; k < M; k++) prod[k] <= PW'(pre[k]) * PW'(active[k]);
      acc <= acc_c;
      {v0, v1, v2, v3} <= {sam_en, v0, v1, v2};
      y_valid <= v3;
      if (v3) y <= y_sat;
      if (coef_wr && 32'(coef_addr) < M) shadow[coef_addr] <= coef_data;
      if (commit_busy) for (int k = 0; k < M; k++) active[k] <= shadow[k];
      commit_busy <= commit_busy ? 1'b0 : coef_commit;
    end
  end
endmodule

// File: tb/tb_rcv_filt_sym_pipe.sv
// tb_rcv_filt_sym_pipe: directed and random stimulus against a convolution-level reference model
module tb_rcv_filt_sym_pipe;
  localparam int N = 21;
  localparam int M = 11;

  logic clk = 0, reset = 1, sam_en = 0, coef_wr = 0, coef_commit = 0;
  logic signed [17:0] x_in = '0, coef_data = '0, y;
  logic [3:0] coef_addr = '0;
  logic commit_busy, y_valid;
  int checks = 0, errors = 0;

  longint hist [N];
  longint sh [M], act [M], act_use [M];
  longint pe [3];
  bit pv [3];
  bit mbusy, pend_v, my_v;
  longint my_y;

  rcv_filt_sym_pipe dut (
    .clk(clk), .reset(reset), .sam_en(sam_en), .x_in(x_in), .coef_wr(coef_wr),
    .coef_addr(coef_addr), .coef_data(coef_data), .coef_commit(coef_commit),
    .commit_busy(commit_busy), .y(y), .y_valid(y_valid)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input longint obs, input longint exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // output = sum over all taps of x[i]*h[i], h symmetric about the centre, scaled by 2^-17
  function automatic longint filt();
    longint a = 0, r;
    for (int i = 0; i < N; i++) a += hist[i] * act_use[i < M ? i : N - 1 - i];
    r = (a + 65536) >>> 17;
    return r > 131071 ? 131071 : r < -131072 ? -131072 : r;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < N; i++) hist[i] = 0;
    for (int k = 0; k < M; k++) begin
      sh[k] = k == M - 1 ? 131071 : 0;
      act[k] = sh[k];
    end
    for (int j = 0; j < 3; j++) begin pv[j] = 0; pe[j] = 0; end
    mbusy = 0; pend_v = 0; my_v = 0; my_y = 0;
  endtask

  task automatic model_edge(input bit se, input longint xv, input bit wr, input int a, input longint d, input bit cm);
    for (int k = 0; k < M; k++) act_use[k] = mbusy ? sh[k] : act[k];
    my_v = pv[2];
    if (pv[2]) my_y = pe[2];
    pv[2] = pv[1]; pe[2] = pe[1];
    pv[1] = pv[0]; pe[1] = pe[0];
    pv[0] = pend_v; pe[0] = filt();
    if (se) begin
      for (int i = N - 1; i > 0; i--) hist[i] = hist[i-1];
      hist[0] = xv;
    end
    if (wr && a < M) sh[a] = d;
    for (int k = 0; k < M; k++) act[k] = act_use[k];
    mbusy = mbusy ? 1'b0 : cm;
    pend_v = se;
  endtask

  task automatic step(input bit se, input longint xv, input bit wr, input int a, input longint d, input bit cm);
    @(negedge clk);
    sam_en = se; x_in = 18'(xv); coef_wr = wr; coef_addr = 4'(a); coef_data = 18'(d); coef_commit = cm;
    @(posedge clk);
    model_edge(se, xv, wr, a, d, cm);
    #1;
    chk("y", y, my_y);
    chk("y_valid", y_valid, my_v);
    chk("commit_busy", commit_busy, mbusy);
  endtask

  task automatic samp(input bit se, input longint xv);
    step(se, xv, 0, 0, 0, 0);
  endtask

  task automatic load_commit(input longint c [M]);
    for (int k = 0; k < M; k++) step(0, 0, 1, k, c[k], 0);
    step(0, 0, 0, 0, 0, 1);
    samp(0, 0);
    samp(0, 0);
  endtask

  task automatic release_reset();
    {sam_en, coef_wr, coef_commit} = '0; x_in = '0; coef_addr = '0; coef_data = '0;
    model_reset();
    @(negedge clk) reset = 0;
    @(posedge clk);
    #1;
  endtask

  initial begin
    longint c [M];
    logic signed [17:0] rx, rd;
    model_reset();
    #12;
    chk("rst_y", y, 0);
    chk("rst_valid", y_valid, 0);
    chk("rst_busy", commit_busy, 0);
    release_reset();

    // pass-through default bank
    for (int i = 0; i < 25; i++) samp(1, 65536);
    chk("passthru", y, 65536);

    // impulse response of a ramp-shaped symmetric bank
    for (int i = 0; i < 25; i++) samp(1, 0);
    for (int k = 0; k < M; k++) c[k] = 1000 * (k + 1);
    load_commit(c);
    samp(1, 65536);
    for (int j = 1; j <= 24; j++) begin
      samp(1, 0);
      if (j >= 4) begin
        chk("imp_y", y, 500 * ((j - 4 < 24 - j ? j - 4 : 24 - j) + 1));
        chk("imp_valid", y_valid, 1);
      end
    end

    // saturation in both directions
    for (int k = 0; k < M; k++) c[k] = 131071;
    load_commit(c);
    for (int i = 0; i < 25; i++) samp(1, 131071);
    chk("sat_pos", y, 131071);
    for (int i = 0; i < 25; i++) samp(1, -131072);
    chk("sat_neg", y, -131072);

    // sparse strobes with a moderate bank
    for (int k = 0; k < M; k++) c[k] = $urandom_range(0, 20000) - 10000;
    load_commit(c);
    for (int i = 0; i < 40; i++) begin
      rx = 18'($urandom);
      samp(i % 3 == 0, rx);
      chk("sparse_valid", y_valid, i >= 4 && (i - 4) % 3 == 0);
    end

    // commit timing while streaming, write on the commit edge included, next edge not
    for (int i = 0; i < 10; i++) begin rx = 18'($urandom); samp(1, rx); end
    rx = 18'($urandom);
    step(1, rx, 1, 0, 20000, 1);
    chk("busy_set", commit_busy, 1);
    rx = 18'($urandom);
    step(1, rx, 1, 1, 30000, 1);
    chk("busy_clr", commit_busy, 0);
    for (int i = 0; i < 10; i++) begin rx = 18'($urandom); samp(1, rx); end
    step(0, 0, 1, M, -5000, 0);
    step(0, 0, 1, 15, 7777, 1);
    for (int i = 0; i < 25; i++) samp(1, 0);
    samp(1, 65536);
    for (int j = 1; j <= 14; j++) begin
      samp(1, 0);
      if (j == 4) chk("edge_wr", y, 10000);
      if (j == 5) chk("late_wr", y, 15000);
    end
    chk("ign_addr", y, (65536 * c[M-1] + 65536) >>> 17);

    // async reset in the middle of a stream
    for (int i = 0; i < 20; i++) begin rx = 18'($urandom); samp(1, rx); end
    #2 reset = 1;
    #1;
    chk("arst_y", y, 0);
    chk("arst_valid", y_valid, 0);
    chk("arst_busy", commit_busy, 0);
    release_reset();
    for (int i = 0; i < 25; i++) samp(1, 65536);
    chk("arst_passthru", y, 65536);

    // randomized mix of strobes, writes and commits
    for (int i = 0; i < 400; i++) begin
      rx = 18'($urandom);
      rd = 18'($urandom);
      step($urandom_range(0, 3) != 0, rx, $urandom_range(0, 3) == 0, $urandom_range(0, 15),
           ($urandom_range(0, 1) != 0) ? longint'(rd) : longint'(rd >>> 4), $urandom_range(0, 9) == 0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
